// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: func3 codes, bus width codes, FSM states.
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] WIDTH_B = 3'b001;
  localparam logic [2:0] WIDTH_H = 3'b010;
  localparam logic [2:0] WIDTH_W = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ST_REQ  = 3'd1,
    S_ST_WAIT = 3'd2,
    S_LD_REQ  = 3'd3,
    S_LD_WAIT = 3'd4,
    S_LD_DONE = 3'd5
  } lsu_state_e;

  // Loads and stores share the low two func3 bits for their access size.
  function automatic logic [2:0] width_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   width_of = WIDTH_B;
      2'b01:   width_of = WIDTH_H;
      default: width_of = WIDTH_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_sb.sv
// Store buffer FIFO for mem_lsu; with MEM_LSU_FWD_EN defined it also offers a
// word-granular match port used for store-to-load forwarding.
module mem_lsu_sb
  import mem_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [ADDR_W-1:0]          push_addr_i,
  input  logic [XLEN-1:0]            push_data_i,
  input  logic [2:0]                 push_width_i,
  output logic [ADDR_W-1:0]          head_addr_o,
  output logic [XLEN-1:0]            head_data_o,
  output logic [2:0]                 head_width_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
`ifdef MEM_LSU_FWD_EN
  ,
  input  logic [ADDR_W-1:0]          match_addr_i,
  input  logic [2:0]                 match_width_i,
  output logic                       match_hit_o,
  output logic [XLEN-1:0]            match_data_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [XLEN-1:0]   data_q  [DEPTH];
  logic [XLEN-1:0]   data_d  [DEPTH];
  logic [2:0]        width_q [DEPTH];
  logic [2:0]        width_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    width_d  = width_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      addr_d[wr_ptr_q]  = push_addr_i;
      data_d[wr_ptr_q]  = push_data_i;
      width_d[wr_ptr_q] = push_width_i;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        width_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      width_q  <= width_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign head_width_o = width_q[rd_ptr_q];
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign count_o      = count_q;

`ifdef MEM_LSU_FWD_EN
  localparam int BYTE_SH = $clog2(XLEN / 8);

  // Walk oldest to youngest so the youngest entry touching the word decides;
  // a younger partial overlap therefore masks an older exact match.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx          = '0;
    match_hit_o  = 1'b0;
    match_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (addr_q[idx][ADDR_W-1:BYTE_SH] == match_addr_i[ADDR_W-1:BYTE_SH])) begin
        match_hit_o  = (addr_q[idx] == match_addr_i) && (width_q[idx] == match_width_i);
        match_data_o = data_q[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: posted stores through mem_lsu_sb, loads ordered behind them.
// Optional store-to-load forwarding is enabled by defining MEM_LSU_FWD_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        func3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              mc_mem_busy_i,
  input  logic              mc_mem_done_i,
  input  logic [XLEN-1:0]   mc_mem_data_i,
  output logic              mc_mem_enable_o,
  output logic              mc_mem_wr_o,
  output logic [ADDR_W-1:0] mc_mem_addr_o,
  output logic [2:0]        mc_mem_width_o,
  output logic [XLEN-1:0]   mc_mem_data_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              stall_req_o,
  output logic              sb_empty_o,
  output logic [2:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  lsu_state_e        state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_ld, is_st, sb_push, sb_pop, sb_full;
  logic [CNT_W-1:0]  sb_count;
  logic [ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]   head_data, st_data;
  logic [2:0]        head_width, op_width;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    case (f3)
      F3_B:    extend = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_H:    extend = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_W:    extend = raw;
      F3_BU:   extend = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_HU:   extend = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: extend = '0;
    endcase
  endfunction

  assign is_ld    = req_valid_i & is_load_i;
  assign is_st    = req_valid_i & is_store_i;
  assign op_width = width_of(func3_i);

  always_comb begin
    case (op_width)
      WIDTH_B: st_data = {{(XLEN-8){1'b0}}, store_data_i[7:0]};
      WIDTH_H: st_data = {{(XLEN-16){1'b0}}, store_data_i[15:0]};
      default: st_data = store_data_i;
    endcase
  end

  // A pop in the same cycle frees the slot a full-buffer push needs.
  assign sb_pop     = (state_q == S_ST_WAIT) & mc_mem_done_i;
  assign sb_push    = is_st & (~sb_full | sb_pop);
  assign sb_empty_o = (sb_count == '0);

`ifdef MEM_LSU_FWD_EN
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
`endif

  mem_lsu_sb #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .push_i       (sb_push),
    .pop_i        (sb_pop),
    .push_addr_i  (addr_i),
    .push_data_i  (st_data),
    .push_width_i (op_width),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .head_width_o (head_width),
    .full_o       (sb_full),
    .count_o      (sb_count)
`ifdef MEM_LSU_FWD_EN
    ,
    .match_addr_i  (addr_i),
    .match_width_i (op_width),
    .match_hit_o   (fwd_hit),
    .match_data_o  (fwd_data)
`endif
  );

  always_comb begin
    state_d         = state_q;
    result_d        = result_q;
    mc_mem_enable_o = 1'b0;
    mc_mem_wr_o     = 1'b0;
    mc_mem_addr_o   = '0;
    mc_mem_width_o  = '0;
    mc_mem_data_o   = '0;
    case (state_q)
      S_IDLE: begin
`ifdef MEM_LSU_FWD_EN
        if (is_ld && fwd_hit) begin
          result_d = extend(fwd_data, func3_i);
          state_d  = S_LD_DONE;
        end else
`endif
        // Older stores always drain first, which also orders loads behind them.
        if (!sb_empty_o) state_d = S_ST_REQ;
        else if (is_ld)  state_d = S_LD_REQ;
      end
      S_ST_REQ: begin
        if (!mc_mem_busy_i) begin
          mc_mem_enable_o = 1'b1;
          mc_mem_wr_o     = 1'b1;
          mc_mem_addr_o   = head_addr;
          mc_mem_width_o  = head_width;
          mc_mem_data_o   = head_data;
          state_d         = S_ST_WAIT;
        end
      end
      S_ST_WAIT: begin
        if (mc_mem_done_i) state_d = S_IDLE;
      end
      S_LD_REQ: begin
        if (!mc_mem_busy_i) begin
          mc_mem_enable_o = 1'b1;
          mc_mem_addr_o   = addr_i;
          mc_mem_width_o  = op_width;
          state_d         = S_LD_WAIT;
        end
      end
      S_LD_WAIT: begin
        if (mc_mem_done_i) begin
          result_d = extend(mc_mem_data_i, func3_i);
          state_d  = S_LD_DONE;
        end
      end
      S_LD_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    if (is_ld) begin
      wd_o        = wd_i;
      stall_req_o = (state_q != S_LD_DONE);
      if (state_q == S_LD_DONE) begin
        wreg_o  = wreg_i;
        wdata_o = result_q;
      end
    end else if (is_st) begin
      wd_o        = wd_i;
      stall_req_o = sb_full & ~sb_pop;
    end else if (req_valid_i) begin
      wd_o    = wd_i;
      wreg_o  = wreg_i;
      wdata_o = wdata_i;
    end
  end

  assign dbg_state_o = state_q;

endmodule
